// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit (0), WIDTH data bits LSB-first, stop bit (1).
// Every bit is held on tx for CLKS_PER_BIT clocks; all outputs come straight from flip-flops.
module serial_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] shift_next;
   logic [CW-1:0]    cyc;
   logic [BW-1:0]    bit_cnt;
   logic             bit_end;

   // tx is registered, so the next data bit is taken from the already-shifted word
   assign shift_next = shift >> 1;
   assign bit_end    = (cyc == CYC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shift   <= '0;
         cyc     <= '0;
         bit_cnt <= '0;
         tx      <= 1'b1;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in && ready) begin
                  shift   <= data_in;
                  cyc     <= '0;
                  bit_cnt <= '0;
                  state   <= START;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
                  tx      <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  cyc   <= '0;
                  state <= DATA;
                  tx    <= shift[0];
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cyc   <= '0;
                  shift <= shift_next;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                     tx      <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shift_next[0];
                  end
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cyc   <= '0;
                  state <= IDLE;
                  tx    <= 1'b1;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/4-clock instance for frame, back-to-back, ignore and
// reset cases, plus a 4-bit/1-clock instance for the single-cycle bit period.
module tb_serial_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid_in = 1'b0;
   logic [7:0] data_in = '0;
   logic       ready, tx, busy, done;

   logic       valid1 = 1'b0;
   logic [3:0] data1 = '0;
   logic       ready1, tx1, busy1, done1;

   int n_assert = 0;
   int n_fail   = 0;

   serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
      .ready(ready), .tx(tx), .busy(busy), .done(done));

   serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut1 (
      .clk(clk), .reset(reset), .valid_in(valid1), .data_in(data1),
      .ready(ready1), .tx(tx1), .busy(busy1), .done(done1));

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected tx for cycle i of a frame (i counted from the first start-bit cycle), 8 bits x 4 clocks.
   function automatic logic exp_tx(input logic [7:0] d, input int i);
      int k;
      k = i / 4;
      if (k == 0) return 1'b0;
      else if (k <= 8) return d[k-1];
      else return 1'b1;
   endfunction

   // Called at the negedge in which valid_in is presented with data d; checks the accept-cycle
   // outputs, then walks n frame cycles. With inject set, a second word is offered mid-frame.
   task automatic run_frame(input logic [7:0] d, input int n, input bit inject, input string tag);
      valid_in = 1'b1;
      data_in  = d;
      tick();
      valid_in = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (inject && i == 15) begin
            valid_in = 1'b1;
            data_in  = 8'hC3;
         end
         if (inject && i == 17) begin
            valid_in = 1'b0;
         end
         check($sformatf("%s_tx_%0d", tag, i), 32'(tx), 32'(exp_tx(d, i)));
         check($sformatf("%s_busy_%0d", tag, i), 32'(busy), 32'd1);
         check($sformatf("%s_ready_%0d", tag, i), 32'(ready), 32'd0);
         check($sformatf("%s_done_%0d", tag, i), 32'(done), 32'd0);
         if (i != n - 1 || n == 40) tick();
      end
   endtask

   initial begin
      // reset held with clock running, then idle hold
      repeat (3) tick();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("idle_%0d", i), {28'd0, tx, ready, busy, done}, 32'b1100);
         check($sformatf("idle1_%0d", i), {28'd0, tx1, ready1, busy1, done1}, 32'b1100);
      end

      // single frame of A5
      run_frame(8'hA5, 40, 1'b0, "a5");
      check("a5_done", 32'(done), 32'd1);
      check("a5_busy_fall", 32'(busy), 32'd0);
      check("a5_ready_back", 32'(ready), 32'd1);
      tick();
      check("a5_done_once", 32'(done), 32'd0);
      repeat (2) tick();

      // back-to-back: FF accepted in the done cycle of the 00 frame
      run_frame(8'h00, 40, 1'b0, "b00");
      check("b00_done", 32'(done), 32'd1);
      check("b00_idle_tx", 32'(tx), 32'd1);
      check("b00_ready", 32'(ready), 32'd1);
      run_frame(8'hFF, 40, 1'b0, "bff");
      check("bff_done", 32'(done), 32'd1);
      tick();
      check("bff_done_clr", 32'(done), 32'd0);
      repeat (2) tick();

      // mid-frame offer of C3 is ignored
      run_frame(8'h3C, 40, 1'b1, "ign");
      check("ign_done", 32'(done), 32'd1);
      check("ign_ready", 32'(ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("ign_idle_%0d", i), {29'd0, tx, ready, busy}, 32'b110);
      end

      // reset asserted during the third data bit of 55, between clock edges
      run_frame(8'h55, 14, 1'b0, "rmid");
      tick();
      check("rmid_busy_pre", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rmid_tx_async", 32'(tx), 32'd1);
      check("rmid_busy_async", 32'(busy), 32'd0);
      check("rmid_ready_async", 32'(ready), 32'd1);
      check("rmid_done_async", 32'(done), 32'd0);
      valid_in = 1'b1;
      data_in  = 8'h81;
      tick();
      tick();
      check("rmid_rst_wins", 32'(busy), 32'd0);
      valid_in = 1'b0;
      reset    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rmid_after_%0d", i), {28'd0, tx, ready, busy, done}, 32'b1100);
      end
      run_frame(8'h81, 40, 1'b0, "r81");
      check("r81_done", 32'(done), 32'd1);
      tick();

      // 4-bit frame, one clock per bit: 1001 -> 0,1,0,0,1,1
      valid1 = 1'b1;
      data1  = 4'b1001;
      tick();
      valid1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [5:0] pat;
         pat = 6'b110010;
         check($sformatf("c1_tx_%0d", i), 32'(tx1), 32'(pat[i]));
         check($sformatf("c1_done_%0d", i), 32'(done1), 32'd0);
         tick();
      end
      check("c1_done", 32'(done1), 32'd1);
      check("c1_busy_fall", 32'(busy1), 32'd0);
      tick();
      check("c1_done_clr", 32'(done1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Framed parallel-to-serial transmitter. Loads a WIDTH-bit word and shifts it out on one line as start bit, data LSB-first, then stop bit.
- It is the transmit end of the team's serial shift-register receiver. It sits between a parallel producer (valid/ready handshake) and the single-wire serial link.
- All outputs are driven from flip-flops.

Parameters:
- WIDTH, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (>=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  producer has a word on data_in.
- data_in  input  WIDTH  parallel word to send.
- ready  output  1  transmitter can accept a word this cycle.
- tx  output  1  serial line; idle level 1.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values, applied immediately on reset assertion, independent of clk:
  - state=IDLE, tx=1, ready=1, busy=0, done=0.
  - shift register=0, bit counter=0, cycle counter=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - ready=1, busy=0, tx=1.
  - Accept occurs on a rising edge with valid_in=1 and ready=1.
  - On accept: capture data_in into the shift register, go to START, clear counters.
  - From the next cycle: ready=0, busy=1, tx=0.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx=shift[0], held CLKS_PER_BIT cycles per bit.
  - At the end of each bit period: shift right by 1 and increment the bit counter.
  - After WIDTH bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- done:
  - Registered. High for exactly the first IDLE cycle after STOP; 0 otherwise.
- Timing:
  - Frame length is (WIDTH+2)*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the end of the stop bit.
  - Accept-to-first-start-bit latency is 1 cycle.
- Back-to-back: an accept in the done cycle is legal. The next start bit then follows after exactly one idle cycle (tx=1).
- Counter widths:
  - cycle counter: clog2(CLKS_PER_BIT) bits, minimum 1.
  - bit counter: clog2(WIDTH+1) bits.
  - Both wrap to 0 at each bit or state boundary; no overflow beyond the terminal count.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; no other change.
- valid_in while busy=1: ignored, no effect, no queuing.
- data_in changes mid-frame: no effect on the serial output, which uses the captured copy.
- Reset mid-frame:
  - Frame is abandoned and tx=1 immediately.
  - No done pulse.
  - After reset deasserts, the block sits in IDLE with ready=1.
- valid_in and reset together: reset wins; no accept.
- Glitch-free: tx changes only on rising clk edges or on reset assertion.

Test Plan:
- Reset then hold: assert reset with clk running, release → tx=1, ready=1, busy=0, done=0 for 20 cycles with valid_in=0.
- Single frame, WIDTH=8, CLKS_PER_BIT=4: accept 8'hA5 → tx, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1. busy high 40 cycles; done pulses once in the cycle busy falls.
- Back-to-back: accept 8'h00, then 8'hFF in its done cycle:
  - first frame: tx low 36 cycles, then 4 high.
  - one idle cycle.
  - second frame: 4 low, then 36 high.
  - done pulses twice.
- Ignored input: mid-frame of 8'h3C, pulse valid_in with data_in=8'hC3 → serial bits remain 8'h3C, no second frame starts, ready stays 0 until IDLE.
- Reset mid-frame: assert reset during the 3rd data bit of 8'h55 → tx=1 the same time step (not waiting for clk), busy=0, no done. A fresh accept of 8'h81 afterwards transmits correctly.
- CLKS_PER_BIT=1, WIDTH=4: accept 4'b1001 → tx=0,1,0,0,1,1 on consecutive cycles; done 6 cycles after the first start-bit cycle.
